multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 50 +++++
 rtl/multicycle_controller_if.sv | 21 ++
 rtl/multicycle_controller_cond_unit.sv | 25 ++
 rtl/multicycle_controller.sv | 138 +++++++++++++
 tb/tb_multicycle_controller.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared state enum, ALU/Op/cmd/condition constants; BL_LINK_EN adds the LINK state
package multicycle_controller_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
`ifdef BL_LINK_EN
    , LINK = 4'd10
`endif
  } state_t;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_ORR = 2'd3;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_NONE = 2'b11;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'ha, CC_LT = 4'hb;
  localparam logic [3:0] CC_GT = 4'hc, CC_LE = 4'hd, CC_AL = 4'he, CC_NV = 4'hf;
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    r = 1'b0;
    case (cc)
      CC_EQ: r = z;
      CC_NE: r = !z;
      CC_CS: r = c;
      CC_CC: r = !c;
      CC_MI: r = n;
      CC_PL: r = !n;
      CC_VS: r = v;
      CC_VC: r = !v;
      CC_HI: r = c && !z;
      CC_LS: r = !c || z;
      CC_GE: r = n == v;
      CC_LT: r = n != v;
      CC_GT: r = !z && n == v;
      CC_LE: r = z || n != v;
      CC_AL: r = 1'b1;
      CC_NV: r = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, memory handshake and datapath controls between controller and datapath
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 4
);
  logic [3:0] Cond, ALUFlags, Rd;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic mem_ready;
  logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  modport master(
    input Cond, ALUFlags, Op, Funct, Rd, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );
  modport slave(
    output Cond, ALUFlags, Op, Funct, Rd, mem_ready,
    input PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// mc_cond_unit: NZCV flag register and condition evaluation for the current instruction
module mc_cond_unit
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       latch,
  input  logic       exec,
  input  logic       s,
  input  logic       cv_en,
  output logic       cond_ex
);
  logic [3:0] flags;
  // Condition is captured in DECODE so later states of the same instruction see pre-update flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      flags <= '0;
      cond_ex <= 1'b0;
    end else begin
      if (latch) cond_ex <= cond_eval(cond, flags);
      if (exec && cond_ex && s) flags <= {alu_flags[3:2], cv_en ? alu_flags[1:0] : flags[1:0]};
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle ARM-subset control FSM with memory-wait timeout; BL_LINK_EN adds BL via a LINK state
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int WAIT_MAX  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master bus,
  output logic [3:0]              state,
  output logic                    mem_timeout
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);
  state_t st, nx;
  logic cond_ex, is_cmp, cv_en, wait_st;
  logic pcw, irw, rw, mw, adr, wb, lsel;
  logic [1:0] rs, sa, sb, alu_op, dp_op;
  logic [3:0] cmd;
  logic [CW-1:0] wcnt;
  logic [ALUCTRL_W-1:0] aluc;
  assign cmd = bus.Funct[4:1];
  assign is_cmp = cmd == CMD_CMP;
  assign cv_en = cmd == CMD_ADD || cmd == CMD_SUB || is_cmp;
  assign dp_op = cmd == CMD_AND ? ALU_AND : (cmd == CMD_SUB || is_cmp) ? ALU_SUB : cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
  assign wait_st = st == FETCH || st == MEMRD || st == MEMWR;
  assign state = st;
  mc_cond_unit u_cond (
    .clk       (clk),
    .reset_n   (reset_n),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .latch     (st == DECODE),
    .exec      (st == EXECR || st == EXECI),
    .s         (bus.Funct[0]),
    .cv_en     (cv_en),
    .cond_ex   (cond_ex)
  );
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= FETCH;
    else st <= nx;
  // Next-state
  always_comb begin
    nx = FETCH;
    case (st)
      FETCH:        nx = bus.mem_ready ? DECODE : FETCH;
      DECODE:       nx = bus.Op == OP_NONE ? FETCH : bus.Op == OP_MEM ? MEMADR : bus.Op == OP_BR ? BRANCH : bus.Funct[5] ? EXECI : EXECR;
      MEMADR:       nx = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:        nx = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:        nx = bus.mem_ready ? FETCH : MEMWR;
      EXECR, EXECI: nx = ALUWB;
`ifdef BL_LINK_EN
      BRANCH:       nx = bus.Funct[4] ? LINK : FETCH;
`endif
      default:      nx = FETCH;
    endcase
  end
  // Per-state controls; ALUSrcB=11 selects constant -4 so LINK stays an ADD; writebacks to R15 go to the PC
  always_comb begin
    {pcw, irw, rw, mw, adr, wb, lsel} = '0;
    {rs, sa, sb} = '0;
    alu_op = ALU_ADD;
    case (st)
      FETCH: begin
        pcw = bus.mem_ready;
        irw = bus.mem_ready;
        sa = 2'b01;
        sb = 2'b10;
        rs = 2'b10;
      end
      DECODE: begin
        sa = 2'b01;
        sb = 2'b10;
        rs = 2'b10;
      end
      MEMADR: sb = 2'b01;
      MEMRD:  adr = 1'b1;
      MEMWR: begin
        adr = 1'b1;
        mw = cond_ex;
      end
      MEMWB: begin
        rs = 2'b01;
        wb = cond_ex;
      end
      EXECR: alu_op = dp_op;
      EXECI: begin
        sb = 2'b01;
        alu_op = dp_op;
      end
      ALUWB: wb = cond_ex && !is_cmp;
      BRANCH: begin
        sb = 2'b01;
        rs = 2'b10;
        pcw = cond_ex;
      end
`ifdef BL_LINK_EN
      LINK: begin
        sa = 2'b01;
        sb = 2'b11;
        rs = 2'b10;
        rw = cond_ex;
        lsel = 1'b1;
      end
`endif
      default: ;
    endcase
    rw = rw || (wb && bus.Rd != 4'd15);
    pcw = pcw || (wb && bus.Rd == 4'd15);
  end
  // Zero-extend the 2-bit ALU code to the configured width
  always_comb begin
    aluc = '0;
    aluc[1:0] = alu_op;
  end
  assign bus.PCWrite    = reset_n && pcw;
  assign bus.IRWrite    = reset_n && irw;
  assign bus.RegWrite   = reset_n && rw;
  assign bus.MemWrite   = reset_n && mw;
  assign bus.AdrSrc     = reset_n && adr;
  assign bus.ResultSrc  = reset_n ? rs : 2'b00;
  assign bus.ALUSrcA    = reset_n ? sa : 2'b00;
  assign bus.ALUSrcB    = reset_n ? sb : 2'b00;
  assign bus.ImmSrc     = reset_n ? bus.Op : 2'b00;
  assign bus.RegSrc     = reset_n ? {lsel, bus.Op == OP_MEM, bus.Op == OP_BR} : 3'b000;
  assign bus.ALUControl = reset_n ? aluc : '0;
  // Wait counter restarts on every state change and saturates; timeout is sticky until reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wcnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wcnt <= nx != st ? '0 : (wait_st && !bus.mem_ready && wcnt != WMAX) ? wcnt + 1'b1 : wcnt;
      mem_timeout <= mem_timeout || wcnt == WMAX;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [3:0] state;
  logic mem_timeout;
  int tests = 0;
  int fails = 0;
  int n;
  logic [3:0] st_log[32];
  logic [3:0] aluc_log[32];
  logic [2:0] rsrc_log[32];
  logic [31:0] rw_log, pcw_log, mw_log, irw_log, adr_log;
  multicycle_controller_if #(.ALUCTRL_W(4)) bus ();
  multicycle_controller #(.ALUCTRL_W(4), .WAIT_MAX(15)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .state       (state),
    .mem_timeout (mem_timeout)
  );
  always #5 clk = ~clk;
  task automatic set_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] fl);
    bus.Cond = cond;
    bus.Op = op;
    bus.Funct = funct;
    bus.Rd = rd;
    bus.ALUFlags = fl;
  endtask
  task automatic run(input logic [31:0] low);
    logic left = 1'b0;
    n = -1;
    {rw_log, pcw_log, mw_log, irw_log, adr_log} = '0;
    for (int i = 0; i < 32; i++) begin
      bus.mem_ready = !low[i];
      @(negedge clk);
      st_log[i] = state;
      aluc_log[i] = bus.ALUControl;
      rsrc_log[i] = bus.RegSrc;
      rw_log[i] = bus.RegWrite;
      pcw_log[i] = bus.PCWrite;
      mw_log[i] = bus.MemWrite;
      irw_log[i] = bus.IRWrite;
      adr_log[i] = bus.AdrSrc;
      if (state != 4'd0) left = 1'b1;
      @(posedge clk);
      #1;
      if (left && state == 4'd0) begin
        n = i + 1;
        break;
      end
    end
    bus.mem_ready = 1'b1;
  endtask
  task automatic test_reset;
    set_instr(4'he, 2'b01, 6'b000001, 4'd15, 4'hf);
    bus.mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    tests++;
    if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d exp 0", state); end
    tests++;
    if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes: got %b exp 00000", {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc});
    end
    tests++;
    if ({bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl} !== 15'b0) begin
      fails++; $display("FAIL reset_selects: got %h exp 0", {bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl});
    end
    tests++;
    if (mem_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b exp 0", mem_timeout); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  task automatic test_add;
    set_instr(4'he, 2'b00, 6'b001001, 4'd1, 4'b0010);
    run(32'h0);
    tests++;
    if (n !== 4) begin fails++; $display("FAIL add_len: got %0d exp 4", n); end
    tests++;
    if ({st_log[0], st_log[1], st_log[2], st_log[3]} !== 16'h0168) begin
      fails++; $display("FAIL add_states: got %h exp 0168", {st_log[0], st_log[1], st_log[2], st_log[3]});
    end
    tests++;
    if ({irw_log[0], pcw_log[0]} !== 2'b11) begin fails++; $display("FAIL add_fetch_strobes: got %b exp 11", {irw_log[0], pcw_log[0]}); end
    tests++;
    if (rw_log[3:0] !== 4'b1000) begin fails++; $display("FAIL add_regwrite: got %b exp 1000", rw_log[3:0]); end
    tests++;
    if (aluc_log[2] !== 4'd0) begin fails++; $display("FAIL add_aluctl: got %0d exp 0", aluc_log[2]); end
    set_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0100);
    run(32'h0);
    tests++;
    if (n !== 3 || st_log[2] !== 4'd9) begin fails++; $display("FAIL beq_len: got %0d/%0d exp 3/9", n, st_log[2]); end
    tests++;
    if (pcw_log[2] !== 1'b0) begin fails++; $display("FAIL beq_after_add: got %b exp 0", pcw_log[2]); end
    set_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run(32'h0);
    tests++;
    if (pcw_log[2] !== 1'b1) begin fails++; $display("FAIL bcs_after_add: got %b exp 1", pcw_log[2]); end
  endtask
  task automatic test_subs_bne;
    set_instr(4'he, 2'b00, 6'b000101, 4'd2, 4'b0100);
    run(32'h0);
    tests++;
    if (n !== 4 || aluc_log[2] !== 4'd1 || rw_log[3] !== 1'b1) begin
      fails++; $display("FAIL subs: got len %0d alu %0d rw %b exp 4 1 1", n, aluc_log[2], rw_log[3]);
    end
    set_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run(32'h0);
    tests++;
    if (st_log[2] !== 4'd9 || pcw_log[2] !== 1'b0) begin fails++; $display("FAIL bne_z1: got st %0d pcw %b exp 9 0", st_log[2], pcw_log[2]); end
    set_instr(4'h1, 2'b00, 6'b001001, 4'd1, 4'b0000);
    run(32'h0);
    tests++;
    if (n !== 4 || rw_log[3] !== 1'b0) begin fails++; $display("FAIL addne_false: got len %0d rw %b exp 4 0", n, rw_log[3]); end
    set_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run(32'h0);
    tests++;
    if (pcw_log[2] !== 1'b1) begin fails++; $display("FAIL beq_z_kept: got %b exp 1", pcw_log[2]); end
    set_instr(4'hf, 2'b00, 6'b001000, 4'd1, 4'b0000);
    run(32'h0);
    tests++;
    if (rw_log[3] !== 1'b0) begin fails++; $display("FAIL cond_nv: got %b exp 0", rw_log[3]); end
  endtask
  task automatic test_cmp;
    set_instr(4'he, 2'b00, 6'b010101, 4'd5, 4'b0000);
    run(32'h0);
    tests++;
    if (n !== 4 || aluc_log[2] !== 4'd1 || {rw_log[3], pcw_log[3]} !== 2'b00) begin
      fails++; $display("FAIL cmp: got len %0d alu %0d rw/pcw %b exp 4 1 00", n, aluc_log[2], {rw_log[3], pcw_log[3]});
    end
    set_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0100);
    run(32'h0);
    tests++;
    if (pcw_log[2] !== 1'b1) begin fails++; $display("FAIL bne_after_cmp: got %b exp 1", pcw_log[2]); end
  endtask
  task automatic test_logic_ops;
    set_instr(4'he, 2'b00, 6'b111000, 4'd4, 4'b0000);
    run(32'h0);
    tests++;
    if (st_log[2] !== 4'd7 || aluc_log[2] !== 4'd3) begin fails++; $display("FAIL orr_imm: got st %0d alu %0d exp 7 3", st_log[2], aluc_log[2]); end
    set_instr(4'he, 2'b00, 6'b000000, 4'd4, 4'b0000);
    run(32'h0);
    tests++;
    if (st_log[2] !== 4'd6 || aluc_log[2] !== 4'd2) begin fails++; $display("FAIL and_reg: got st %0d alu %0d exp 6 2", st_log[2], aluc_log[2]); end
    set_instr(4'he, 2'b00, 6'b001000, 4'd15, 4'b0000);
    run(32'h0);
    tests++;
    if ({rw_log[3], pcw_log[3]} !== 2'b01) begin fails++; $display("FAIL rd15: got rw/pcw %b exp 01", {rw_log[3], pcw_log[3]}); end
  endtask
  task automatic test_mem;
    set_instr(4'he, 2'b01, 6'b011001, 4'd3, 4'b0000);
    run(32'h38);
    tests++;
    if (n !== 8) begin fails++; $display("FAIL ldr_len: got %0d exp 8", n); end
    tests++;
    if ({st_log[3], st_log[4], st_log[5], st_log[6], st_log[7]} !== 20'h33334) begin
      fails++; $display("FAIL ldr_states: got %h exp 33334", {st_log[3], st_log[4], st_log[5], st_log[6], st_log[7]});
    end
    tests++;
    if (rw_log[7:0] !== 8'h80 || adr_log[3] !== 1'b1) begin fails++; $display("FAIL ldr_strobes: got rw %b adr %b exp 10000000 1", rw_log[7:0], adr_log[3]); end
    tests++;
    if (mem_timeout !== 1'b0) begin fails++; $display("FAIL ldr_no_timeout: got %b exp 0", mem_timeout); end
    set_instr(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000);
    run(32'h0);
    tests++;
    if (n !== 4 || st_log[3] !== 4'd5 || mw_log[3:0] !== 4'b1000) begin
      fails++; $display("FAIL str: got len %0d st %0d mw %b exp 4 5 1000", n, st_log[3], mw_log[3:0]);
    end
    set_instr(4'hf, 2'b01, 6'b011000, 4'd3, 4'b0000);
    run(32'h0);
    tests++;
    if (mw_log[3:0] !== 4'b0000) begin fails++; $display("FAIL str_false: got %b exp 0000", mw_log[3:0]); end
    set_instr(4'he, 2'b11, 6'b001001, 4'd1, 4'b0000);
    run(32'h0);
    tests++;
    if (n !== 2 || rw_log[1:0] !== 2'b00 || mw_log[1:0] !== 2'b00) begin
      fails++; $display("FAIL op11: got len %0d rw %b mw %b exp 2 00 00", n, rw_log[1:0], mw_log[1:0]);
    end
  endtask
  task automatic test_branch_link;
    set_instr(4'he, 2'b10, 6'b010000, 4'd0, 4'b0000);
    run(32'h0);
`ifdef BL_LINK_EN
    tests++;
    if (n !== 4 || st_log[3] !== 4'd10) begin fails++; $display("FAIL bl_len: got %0d st %0d exp 4 10", n, st_log[3]); end
    tests++;
    if (rw_log[3] !== 1'b1 || rsrc_log[3][2] !== 1'b1) begin fails++; $display("FAIL bl_link: got rw %b r14 %b exp 1 1", rw_log[3], rsrc_log[3][2]); end
`else
    tests++;
    if (n !== 3 || rw_log[2:0] !== 3'b000) begin fails++; $display("FAIL b_funct4_ignored: got len %0d rw %b exp 3 000", n, rw_log[2:0]); end
`endif
  endtask
  task automatic test_reset_memwr;
    set_instr(4'he, 2'b00, 6'b000101, 4'd2, 4'b0100);
    run(32'h0);
    set_instr(4'he, 2'b01, 6'b011000, 4'd3, 4'b0000);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (state !== 4'd5 || bus.MemWrite !== 1'b1) begin fails++; $display("FAIL memwr_hold: got st %0d mw %b exp 5 1", state, bus.MemWrite); end
    reset_n = 1'b0;
    #1;
    tests++;
    if (state !== 4'd0 || bus.MemWrite !== 1'b0 || bus.AdrSrc !== 1'b0) begin
      fails++; $display("FAIL memwr_reset: got st %0d mw %b adr %b exp 0 0 0", state, bus.MemWrite, bus.AdrSrc);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    set_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0100);
    run(32'h0);
    tests++;
    if (n !== 3 || pcw_log[2] !== 1'b0) begin fails++; $display("FAIL flags_cleared: got len %0d pcw %b exp 3 0", n, pcw_log[2]); end
  endtask
  task automatic test_timeout;
    set_instr(4'he, 2'b01, 6'b011001, 4'd3, 4'b0000);
    run(32'h007f_fff8);
    tests++;
    if (n !== 25 || mem_timeout !== 1'b1) begin fails++; $display("FAIL timeout_set: got len %0d to %b exp 25 1", n, mem_timeout); end
    set_instr(4'he, 2'b00, 6'b001000, 4'd1, 4'b0000);
    run(32'h0);
    tests++;
    if (mem_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b exp 1", mem_timeout); end
    reset_n = 1'b0;
    #1;
    tests++;
    if (mem_timeout !== 1'b0 || state !== 4'd0) begin fails++; $display("FAIL timeout_reset: got to %b st %0d exp 0 0", mem_timeout, state); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_subs_bne;
    test_cmp;
    test_logic_ops;
    test_mem;
    test_branch_link;
    test_reset_memwr;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
